// File: rtl/uart_rx_os16_if.sv
// Receive-side bundle between the UART receiver and the RX async FIFO write port.
// master: receiver (drives byte strobe, flags, overrun; reads FIFO full). slave: FIFO side.
`timescale 1ns/1ps
interface uart_rx_os16_if;
    logic       oRX_VALID;
    logic [7:0] oRX_DATA;
    logic       oFRAME_ERR;
    logic       oPARITY_ERR;
    logic       oOVERRUN;
    logic       iFIFO_FULL;

    modport master (
        output oRX_VALID, oRX_DATA, oFRAME_ERR,
        output oPARITY_ERR, oOVERRUN,
        input  iFIFO_FULL
    );
    modport slave (
        input  oRX_VALID, oRX_DATA, oFRAME_ERR,
        input  oPARITY_ERR, oOVERRUN,
        output iFIFO_FULL
    );
endinterface

// File: rtl/uart_rx_os16.sv
// Oversampling UART receiver: 2-flop sync, start validation, 3-sample majority vote.
// Ports: iUART_CLOCK, inRESET (async low), iSAMPLE_EN, iRX_EN, iUART_RXD, rx bundle, oBUSY.
`timescale 1ns/1ps
module uart_rx_os16 #(
    parameter int P_OVERSAMPLE = 16,
    parameter int P_PARITY_EN  = 0,
    parameter int P_PARITY_ODD = 0,
    parameter int P_MSB_FIRST  = 1
) (
    input  logic          iUART_CLOCK,
    input  logic          inRESET,
    input  logic          iSAMPLE_EN,
    input  logic          iRX_EN,
    input  logic          iUART_RXD,
    uart_rx_os16_if.master rx,
    output logic          oBUSY
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    localparam logic [3:0] HALF = 4'(P_OVERSAMPLE / 2 - 1);
    localparam logic [3:0] FULL = 4'(P_OVERSAMPLE - 1);
    localparam logic       PODD = (P_PARITY_ODD != 0);
    localparam logic       PEN  = (P_PARITY_EN != 0);
    localparam logic       MSBF = (P_MSB_FIRST != 0);

    state_t     state;
    logic [1:0] sync;
    logic [2:0] vote;
    logic [3:0] tcnt;
    logic [2:0] bcnt;
    logic [7:0] shreg;
    logic       perr;

    logic       rxd_s;
    logic [2:0] vote_n;
    logic       maj;
    logic [7:0] shreg_n;

    assign rxd_s  = sync[1];
    // The vote includes the sample taken on the evaluation tick itself.
    assign vote_n = {vote[1:0], rxd_s};
    assign maj    = (vote_n[0] & vote_n[1]) |
                    (vote_n[0] & vote_n[2]) |
                    (vote_n[1] & vote_n[2]);
    assign shreg_n = MSBF ? {shreg[6:0], maj} : {maj, shreg[7:1]};
    assign oBUSY   = (state != S_IDLE);

    always_ff @(posedge iUART_CLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state          <= S_IDLE;
            sync           <= 2'b11;
            vote           <= 3'b111;
            tcnt           <= '0;
            bcnt           <= '0;
            shreg          <= '0;
            perr           <= 1'b0;
            rx.oRX_VALID   <= 1'b0;
            rx.oRX_DATA    <= 8'h00;
            rx.oFRAME_ERR  <= 1'b0;
            rx.oPARITY_ERR <= 1'b0;
            rx.oOVERRUN    <= 1'b0;
        end else begin
            sync           <= {sync[0], iUART_RXD};
            rx.oRX_VALID   <= 1'b0;
            rx.oFRAME_ERR  <= 1'b0;
            rx.oPARITY_ERR <= 1'b0;
            rx.oOVERRUN    <= 1'b0;
            if (state != S_IDLE && !iRX_EN) begin
                // Abort wins over any tick in progress.
                state <= S_IDLE;
                tcnt  <= '0;
                bcnt  <= '0;
            end else if (iSAMPLE_EN) begin
                vote <= vote_n;
                tcnt <= tcnt + 4'd1;
                unique case (state)
                    S_IDLE: begin
                        tcnt <= '0;
                        if (iRX_EN && !rxd_s)
                            state <= S_START;
                    end
                    S_START: begin
                        if (tcnt == HALF) begin
                            tcnt  <= '0;
                            bcnt  <= '0;
                            perr  <= 1'b0;
                            state <= maj ? S_IDLE : S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (tcnt == FULL) begin
                            tcnt  <= '0;
                            shreg <= shreg_n;
                            bcnt  <= bcnt + 3'd1;
                            if (bcnt == 3'd7)
                                state <= PEN ? S_PARITY : S_STOP;
                        end
                    end
                    S_PARITY: begin
                        if (tcnt == FULL) begin
                            tcnt  <= '0;
                            perr  <= (^shreg) ^ maj ^ PODD;
                            state <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (tcnt == FULL) begin
                            tcnt <= '0;
                            if (rx.iFIFO_FULL) begin
                                rx.oOVERRUN <= 1'b1;
                            end else begin
                                rx.oRX_VALID   <= 1'b1;
                                rx.oRX_DATA    <= shreg;
                                rx.oFRAME_ERR  <= ~maj;
                                rx.oPARITY_ERR <= perr & PEN;
                            end
                            // A low stop bit may be a break; wait for idle.
                            state <= maj ? S_IDLE : S_WAIT_HIGH;
                        end
                    end
                    S_WAIT_HIGH: begin
                        tcnt <= '0;
                        if (rxd_s)
                            state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
